// File: rtl/uart_deserializer_if.sv
// Parallel output side of the UART receive stage: word holding register with
// valid/ready handshake plus one-cycle error pulses.
interface uart_deserializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output out_data, out_valid, frame_err, parity_err, overrun,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, frame_err, parity_err, overrun,
        output out_ready
    );
endinterface

// File: rtl/uart_deserializer.sv
// UART receive stage: samples rx on baud-clock rising edges, assembles
// start/data/parity/stop bits and hands words out through a one-entry buffer.
module uart_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enabled,
    input  logic                rx,
    input  logic                rxClk,
    uart_deserializer_if.master bus
);
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_deserializer: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_deserializer: DATA_BITS must be 5..9");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rxclk_q;
    logic [3:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_par_bad;

    assign w_tick    = rxClk && !r_rxclk_q;
    assign w_par_bad = (PARITY_EN != 0) && ((^{r_shift, r_par_bit}) != 1'(PARITY_ODD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rxclk_q    <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_s       <= r_rx_meta;
            r_rxclk_q    <= rxClk;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            if (!enabled) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
            end else begin
                // A commit below overrides this drop, keeping the buffer full.
                if (r_valid && bus.out_ready) begin
                    r_valid <= 1'b0;
                end
                if (w_tick) begin
                    case (r_state)
                        S_IDLE: begin
                            if (!r_rx_s) begin
                                r_bit_cnt  <= '0;
                                r_stop_cnt <= 1'b0;
                                r_state    <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end
                        end
                        S_PARITY: begin
                            r_par_bit <= r_rx_s;
                            r_state   <= S_STOP;
                        end
                        S_STOP: begin
                            if (!r_rx_s) begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end else if (STOP_BITS == 2 && !r_stop_cnt) begin
                                r_stop_cnt <= 1'b1;
                            end else begin
                                r_state      <= S_IDLE;
                                r_parity_err <= w_par_bad;
                                if (!r_valid || bus.out_ready) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end
                        S_BREAK: begin
                            if (r_rx_s) begin
                                r_state <= S_IDLE;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.out_data   = r_data;
    assign bus.out_valid  = r_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.parity_err = r_parity_err;
    assign bus.overrun    = r_overrun;
endmodule
